wb_interconnect_rr: RTL and testbench
=====================================

WB_INTERCONNECT_RR -- requirements
Module: wb_interconnect_rr

Interface
REQ-001 Parameter NUMM, default 3: number of Wishbone masters, 1..8.
REQ-002 Parameter NUMS, default 3: number of Wishbone slaves, 1..16.
REQ-003 Parameter BASE_ADDR, default {32'h1A110000, 32'h00000000, 32'h10000000}: NUMS x 32-bit slave base addresses; index 0 is the MSB word.
REQ-004 Parameter SIZE, default {32'h1000, 32'h10000, 32'h1000}: NUMS x 32-bit region sizes, each a power of two; BASE_ADDR aligned to SIZE.
REQ-005 Parameter TIMEOUT, default 255: watchdog limit in cycles, 1..65535.
REQ-006 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wbm  wb_if  NUMM  master-side ports: cyc, stb, we, adr[31:0], sel[3:0], dat_m2s[31:0] in; dat_s2m[31:0], ack, err out.
REQ-009 wbs  wb_if  NUMS  slave-side ports, same signals with directions reversed.

Function
REQ-010 The arbiter SHALL have three states: IDLE, BUSY and ERRRSP.
REQ-011 IDLE SHALL grant, at the next clock edge, the requesting master (cyc=1) found first when searching round-robin from (last_grant+1) mod NUMM, and then enter BUSY.
REQ-012 last_grant SHALL reset to NUMM-1, so that master 0 has first priority after reset.
REQ-013 The grant SHALL be held in BUSY while the granted master's cyc=1; when cyc=0 the arbiter SHALL return to IDLE at the next edge, with no new grant in that same cycle.
REQ-014 Decode SHALL be combinational on the granted master's adr: a slave matches when (adr & ~(SIZE-1)) == BASE_ADDR; if several match, the lowest index wins.
REQ-015 Only the matched slave SHALL see cyc/stb asserted; all slaves SHALL receive the granted master's we, adr, sel and dat_m2s.
REQ-016 The granted master SHALL receive the matched slave's ack, err and dat_s2m combinationally, with zero added latency.
REQ-017 Non-granted masters SHALL see ack=0 and err=0 at all times; dat_s2m is don't-care.
REQ-018 stb=1 to an unmapped address SHALL drive no slave, move BUSY->ERRRSP, and assert err for exactly one cycle to the granted master on the next cycle; the arbiter then returns to BUSY.
REQ-019 If the granted master drops cyc in the same cycle as ack, the grant SHALL be released at that edge.
REQ-020 In BUSY with stb=0 and cyc=1 (block transfer gap), the grant SHALL be held.
REQ-021 After reset, all outputs SHALL be 0: slave cyc/stb, master ack/err, and all data/address buses.

Reset
REQ-022 Assertion of rst_n=0 SHALL immediately (asynchronously) force IDLE, clear the grant, zero the watchdog and set last_grant to NUMM-1.
REQ-023 Reset in mid-transfer SHALL drop slave cyc/stb combinationally, without waiting for ack.
REQ-024 Deassertion SHALL be synchronous to clk; the system sync_reset block provides this.

Configuration
REQ-025 Macro WB_INTERCON_TIMEOUT_EN: when defined, a 16-bit watchdog SHALL count cycles with granted stb=1 and neither ack nor err, and clear on ack, err or stb=0.
REQ-026 With WB_INTERCON_TIMEOUT_EN defined, when the count reaches TIMEOUT the block SHALL deassert the slave's stb/cyc, enter ERRRSP, and issue a one-cycle err to the master.
REQ-027 Without WB_INTERCON_TIMEOUT_EN, the watchdog logic SHALL be absent and a hung slave stalls the bus indefinitely.

Verification
REQ-028 Master 0 reads 32'h00000010; RAM acks on 2nd cycle with 32'hDEADBEEF -> master 0 sees ack and 32'hDEADBEEF in the same cycle; only wbs[1].stb is asserted.
REQ-029 Masters 0, 1 and 2 hold cyc=1 continuously, each doing single transfers -> the grant order after reset is 0,1,2,0,1,2, with one IDLE cycle between grants.
REQ-030 Master 2 writes 32'h20000000 (unmapped) -> no slave stb; err=1 for exactly one cycle to master 2 one cycle later; ack stays 0.
REQ-031 With WB_INTERCON_TIMEOUT_EN and TIMEOUT=8, the GPIO slave never acks -> slave stb drops and master err=1 on cycle 9 after stb; the next master is granted afterwards.
REQ-032 rst_n pulsed low during a BUSY transfer by master 1 -> all slave cyc/stb go 0 without a clock edge; after release, master 0 wins when both master 0 and master 1 request.
REQ-033 Master 1 does a 4-beat block with one-cycle stb=0 gaps while master 0 requests -> master 1 keeps the grant until it drops cyc; master 0 is granted two cycles later.

Source files
------------

// File: rtl/wb_interconnect_rr_if.sv
// Wishbone bundle for N ports; per-port signals are packed along the first dimension.
// Devices that initiate cycles use the master modport, devices that respond use slave.
interface wb_if #(parameter int N = 1);
   logic [N-1:0]       cyc;
   logic [N-1:0]       stb;
   logic [N-1:0]       we;
   logic [N-1:0][31:0] adr;
   logic [N-1:0][3:0]  sel;
   logic [N-1:0][31:0] dat_m2s;
   logic [N-1:0][31:0] dat_s2m;
   logic [N-1:0]       ack;
   logic [N-1:0]       err;

   modport master (output cyc, stb, we, adr, sel, dat_m2s, input dat_s2m, ack, err);
   modport slave  (input cyc, stb, we, adr, sel, dat_m2s, output dat_s2m, ack, err);
endinterface

// File: rtl/wb_interconnect_rr.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration, address decode, error response.
// Optional bus watchdog enabled by defining WB_INTERCON_TIMEOUT_EN.
module wb_interconnect_rr #(
   parameter int                 NUMM      = 3,
   parameter int                 NUMS      = 3,
   parameter logic [NUMS*32-1:0] BASE_ADDR = {32'h1A110000, 32'h00000000, 32'h10000000},
   parameter logic [NUMS*32-1:0] SIZE      = {32'h1000, 32'h10000, 32'h1000},
   parameter int                 TIMEOUT   = 255
) (
   input logic  clk,
   input logic  rst_n,
   wb_if.slave  wbm,
   wb_if.master wbs
);
   localparam int MW = (NUMM > 1) ? $clog2(NUMM) : 1;
   localparam int SW = (NUMS > 1) ? $clog2(NUMS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ERRRSP} state_t;

   state_t        state;
   logic [MW-1:0] gnt, last_grant, nxt;
   logic          req_any, busy, active;
   logic          g_cyc, g_stb, g_we;
   logic [31:0]   g_adr, g_dat;
   logic [3:0]    g_sel;
   logic          hit;
   logic [SW-1:0] hit_idx;
   logic          s_ack, s_err;
   logic [31:0]   s_dat;
   logic          wd_fire;

   assign busy   = (state == BUSY);
   assign active = (state != IDLE);

   // Search starts just after the last winner; iterating downward lets the nearest requester win.
   always_comb begin
      nxt     = last_grant;
      req_any = 1'b0;
      for (int k = NUMM; k >= 1; k--)
         for (int m = 0; m < NUMM; m++)
            if (m == (int'(last_grant) + k) % NUMM && wbm.cyc[m]) begin
               nxt     = MW'(m);
               req_any = 1'b1;
            end
   end

   always_comb begin
      g_cyc = 1'b0; g_stb = 1'b0; g_we = 1'b0;
      g_adr = '0;   g_dat = '0;   g_sel = '0;
      for (int m = 0; m < NUMM; m++)
         if (gnt == MW'(m)) begin
            g_cyc = wbm.cyc[m];
            g_stb = wbm.stb[m];
            g_we  = wbm.we[m];
            g_adr = wbm.adr[m];
            g_dat = wbm.dat_m2s[m];
            g_sel = wbm.sel[m];
         end
   end

   // Downward scan so the lowest matching slave index is the last assignment.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int s = NUMS-1; s >= 0; s--)
         if ((g_adr & ~(SIZE[(NUMS-1-s)*32 +: 32] - 32'd1)) == BASE_ADDR[(NUMS-1-s)*32 +: 32]) begin
            hit     = 1'b1;
            hit_idx = SW'(s);
         end
   end

   always_comb begin
      s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
      for (int s = 0; s < NUMS; s++)
         if (hit && hit_idx == SW'(s)) begin
            s_ack = wbs.ack[s];
            s_err = wbs.err[s];
            s_dat = wbs.dat_s2m[s];
         end
   end

   always_comb begin
      wbs.cyc = '0; wbs.stb = '0; wbs.we = '0;
      wbs.adr = '0; wbs.sel = '0; wbs.dat_m2s = '0;
      for (int s = 0; s < NUMS; s++) begin
         wbs.cyc[s] = busy && g_cyc && hit && hit_idx == SW'(s);
         wbs.stb[s] = busy && g_stb && hit && hit_idx == SW'(s);
         if (active) begin
            wbs.we[s]      = g_we;
            wbs.adr[s]     = g_adr;
            wbs.sel[s]     = g_sel;
            wbs.dat_m2s[s] = g_dat;
         end
      end
   end

   always_comb begin
      wbm.ack = '0; wbm.err = '0; wbm.dat_s2m = '0;
      for (int m = 0; m < NUMM; m++)
         if (active && gnt == MW'(m)) begin
            wbm.ack[m]     = busy && s_ack;
            wbm.err[m]     = (busy && s_err) || (state == ERRRSP);
            wbm.dat_s2m[m] = busy ? s_dat : 32'd0;
         end
   end

`ifdef WB_INTERCON_TIMEOUT_EN
   localparam logic [15:0] TO16 = 16'(TIMEOUT);
   logic [15:0] wdog;

   assign wd_fire = busy && g_stb && hit && !s_ack && !s_err && (wdog == TO16);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                               wdog <= '0;
      else if (busy && g_stb && hit && !s_ack && !s_err && !wd_fire) wdog <= wdog + 16'd1;
      else                                                      wdog <= '0;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         last_grant <= MW'(NUMM-1);
      end else begin
         case (state)
            IDLE: if (req_any) begin
               gnt        <= nxt;
               last_grant <= nxt;
               state      <= BUSY;
            end
            BUSY: begin
               if (!g_cyc) begin
                  state <= IDLE;
                  gnt   <= '0;
               end else if ((g_stb && !hit) || wd_fire) begin
                  state <= ERRRSP;
               end
            end
            ERRRSP:  state <= BUSY;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_interconnect_rr.sv
// Directed bench for wb_interconnect_rr: decode, round-robin, error response, reset, block hold.
// Defining WB_INTERCON_TIMEOUT_EN also builds the watchdog scenario with TIMEOUT=8.
module tb_wb_interconnect_rr;
   localparam int NUMM = 3;
   localparam int NUMS = 3;
`ifdef WB_INTERCON_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [NUMS-1:0] ack_r, hang;

   wb_if #(.N(NUMM)) wbm();
   wb_if #(.N(NUMS)) wbs();

   wb_interconnect_rr #(.NUMM(NUMM), .NUMS(NUMS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .wbm(wbm), .wbs(wbs));

   always #5 clk = ~clk;

   // Slaves ack one cycle after seeing stb unless told to hang.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) ack_r <= '0;
      else        ack_r <= wbs.stb & ~ack_r & ~hang;

   assign wbs.ack        = ack_r;
   assign wbs.err        = '0;
   assign wbs.dat_s2m[0] = 32'hA0A0A0A0;
   assign wbs.dat_s2m[1] = 32'hDEADBEEF;
   assign wbs.dat_s2m[2] = 32'hC0C0C0C0;

   task automatic idle_masters();
      wbm.cyc = '0; wbm.stb = '0; wbm.we = '0;
      wbm.adr = '0; wbm.sel = '0; wbm.dat_m2s = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; idle_masters(); hang = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle_masters(); hang = '0;
      wbm.cyc = '1; wbm.stb = '1;
      @(negedge clk); #1;
      n_cmp++; if (wbs.cyc !== '0) begin n_bad++; $display("FAIL rst_cyc: got %h want 0", wbs.cyc); end
      n_cmp++; if (wbs.stb !== '0) begin n_bad++; $display("FAIL rst_stb: got %h want 0", wbs.stb); end
      n_cmp++; if (wbs.adr !== '0) begin n_bad++; $display("FAIL rst_adr: got %h want 0", wbs.adr); end
      n_cmp++; if (wbm.ack !== '0) begin n_bad++; $display("FAIL rst_ack: got %h want 0", wbm.ack); end
      n_cmp++; if (wbm.err !== '0) begin n_bad++; $display("FAIL rst_err: got %h want 0", wbm.err); end
      n_cmp++; if (wbm.dat_s2m !== '0) begin n_bad++; $display("FAIL rst_dat: got %h want 0", wbm.dat_s2m); end
      idle_masters();
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      do_reset();
      wbm.cyc[0] = 1'b1; wbm.stb[0] = 1'b1; wbm.adr[0] = 32'h10; wbm.sel[0] = 4'hF;
      @(negedge clk); #1;
      n_cmp++; if (wbs.stb !== 3'b010) begin n_bad++; $display("FAIL read_stb: got %b want 010", wbs.stb); end
      n_cmp++; if (wbm.ack !== 3'b000) begin n_bad++; $display("FAIL read_early_ack: got %b want 000", wbm.ack); end
      @(negedge clk); #1;
      n_cmp++; if (wbm.ack !== 3'b001) begin n_bad++; $display("FAIL read_ack: got %b want 001", wbm.ack); end
      n_cmp++; if (wbm.dat_s2m[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", wbm.dat_s2m[0]); end
      idle_masters();
      @(negedge clk); #1;
      n_cmp++; if (wbs.cyc !== 3'b000) begin n_bad++; $display("FAIL read_release: got %b want 000", wbs.cyc); end
   endtask

   task automatic test_round_robin();
      int order[6];
      int when[6];
      int na = 0;
      logic [NUMM-1:0] drop = '0;
      logic [NUMM-1:0] nd;
      for (int i = 0; i < 6; i++) begin order[i] = -1; when[i] = -1; end
      do_reset();
      wbm.cyc = '1; wbm.stb = '1;
      for (int m = 0; m < NUMM; m++) wbm.adr[m] = 32'h10;
      for (int c = 1; c <= 24 && na < 6; c++) begin
         @(negedge clk); #1;
         if (drop != '0) begin
            n_cmp++; if (wbs.cyc !== '0) begin n_bad++; $display("FAIL rr_idle_gap: got %b want 000 at cycle %0d", wbs.cyc, c); end
         end
         nd = wbm.ack;
         for (int m = 0; m < NUMM; m++)
            if (nd[m]) begin
               if (na < 6) begin order[na] = m; when[na] = c; end
               na++;
            end
         wbm.cyc = (wbm.cyc | drop) & ~nd;
         wbm.stb = (wbm.stb | drop) & ~nd;
         drop = nd;
      end
      n_cmp++; if (na !== 6) begin n_bad++; $display("FAIL rr_count: got %0d grants want 6", na); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (order[i] !== i % 3) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 3); end
      end
      for (int i = 1; i < 6; i++) begin
         n_cmp++; if (when[i] - when[i-1] !== 3) begin n_bad++; $display("FAIL rr_spacing[%0d]: got %0d want 3", i, when[i] - when[i-1]); end
      end
      idle_masters();
   endtask

   task automatic test_unmapped();
      do_reset();
      wbm.cyc[2] = 1'b1; wbm.stb[2] = 1'b1; wbm.we[2] = 1'b1; wbm.adr[2] = 32'h20000000;
      @(negedge clk); #1;
      n_cmp++; if (wbs.stb !== 3'b000) begin n_bad++; $display("FAIL unm_stb: got %b want 000", wbs.stb); end
      n_cmp++; if (wbm.err !== 3'b000) begin n_bad++; $display("FAIL unm_err_early: got %b want 000", wbm.err); end
      @(negedge clk); #1;
      n_cmp++; if (wbm.err !== 3'b100) begin n_bad++; $display("FAIL unm_err: got %b want 100", wbm.err); end
      n_cmp++; if (wbm.ack !== 3'b000) begin n_bad++; $display("FAIL unm_ack: got %b want 000", wbm.ack); end
      n_cmp++; if (wbs.stb !== 3'b000) begin n_bad++; $display("FAIL unm_stb_err: got %b want 000", wbs.stb); end
      idle_masters();
      @(negedge clk); #1;
      n_cmp++; if (wbm.err !== 3'b000) begin n_bad++; $display("FAIL unm_err_once: got %b want 000", wbm.err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      hang[1] = 1'b1;
      wbm.cyc[1] = 1'b1; wbm.stb[1] = 1'b1; wbm.adr[1] = 32'h20;
      @(negedge clk); #1;
      n_cmp++; if (wbs.stb !== 3'b010) begin n_bad++; $display("FAIL rmid_busy: got %b want 010", wbs.stb); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (wbs.cyc !== 3'b000) begin n_bad++; $display("FAIL rmid_cyc: got %b want 000", wbs.cyc); end
      n_cmp++; if (wbs.stb !== 3'b000) begin n_bad++; $display("FAIL rmid_stb: got %b want 000", wbs.stb); end
      hang = '0;
      wbm.cyc[0] = 1'b1; wbm.stb[0] = 1'b1; wbm.adr[0] = 32'h10;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (wbs.adr[1] !== 32'h10) begin n_bad++; $display("FAIL rmid_m0_wins: got %h want 00000010", wbs.adr[1]); end
      n_cmp++; if (wbs.stb !== 3'b010) begin n_bad++; $display("FAIL rmid_stb_after: got %b want 010", wbs.stb); end
      idle_masters();
   endtask

   task automatic test_back_to_back();
      int beats = 0;
      do_reset();
      wbm.cyc[1] = 1'b1; wbm.stb[1] = 1'b1; wbm.adr[1] = 32'h10;
      @(negedge clk);
      wbm.cyc[0] = 1'b1; wbm.stb[0] = 1'b1; wbm.adr[0] = 32'h100;
      for (int c = 0; c < 30 && beats < 4; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (wbs.adr[1] !== 32'h10 || wbm.ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL blk_hold: adr %h ack0 %b want 00000010 0", wbs.adr[1], wbm.ack[0]);
         end
         if (!wbm.stb[1]) begin
            n_cmp++; if (wbs.cyc !== 3'b010 || wbs.stb !== 3'b000) begin
               n_bad++; $display("FAIL blk_gap: cyc %b stb %b want 010 000", wbs.cyc, wbs.stb);
            end
         end
         if (wbm.ack[1]) begin
            beats++;
            wbm.stb[1] = 1'b0;
            if (beats == 4) wbm.cyc[1] = 1'b0;
         end else begin
            wbm.stb[1] = 1'b1;
         end
      end
      n_cmp++; if (beats !== 4) begin n_bad++; $display("FAIL blk_beats: got %0d want 4", beats); end
      @(negedge clk); #1;
      n_cmp++; if (wbs.cyc !== 3'b000) begin n_bad++; $display("FAIL blk_idle: got %b want 000", wbs.cyc); end
      @(negedge clk); #1;
      n_cmp++; if (wbs.adr[1] !== 32'h100) begin n_bad++; $display("FAIL blk_m0_gnt: got %h want 00000100", wbs.adr[1]); end
      n_cmp++; if (wbs.stb !== 3'b010) begin n_bad++; $display("FAIL blk_m0_stb: got %b want 010", wbs.stb); end
      idle_masters();
   endtask

`ifdef WB_INTERCON_TIMEOUT_EN
   task automatic test_timeout();
      int  stb_cyc = 0;
      bit  got_err = 1'b0;
      bit  m1_seen = 1'b0;
      do_reset();
      hang[0] = 1'b1;
      wbm.cyc[0] = 1'b1; wbm.stb[0] = 1'b1; wbm.adr[0] = 32'h1A110000;
      wbm.cyc[1] = 1'b1; wbm.stb[1] = 1'b1; wbm.adr[1] = 32'h10;
      for (int c = 0; c < 20 && !got_err; c++) begin
         @(negedge clk); #1;
         if (wbs.stb[0]) stb_cyc++;
         if (wbm.err[0]) begin
            got_err = 1'b1;
            n_cmp++; if (wbs.stb !== 3'b000) begin n_bad++; $display("FAIL to_stb_drop: got %b want 000", wbs.stb); end
            wbm.cyc[0] = 1'b0; wbm.stb[0] = 1'b0;
         end
      end
      n_cmp++; if (!got_err) begin n_bad++; $display("FAIL to_err: got none want err"); end
      n_cmp++; if (stb_cyc !== 9) begin n_bad++; $display("FAIL to_stb_cycles: got %0d want 9", stb_cyc); end
      for (int c = 0; c < 6 && !m1_seen; c++) begin
         @(negedge clk); #1;
         if (wbs.stb[1] && wbs.adr[1] === 32'h10) m1_seen = 1'b1;
      end
      n_cmp++; if (!m1_seen) begin n_bad++; $display("FAIL to_next_gnt: master 1 not granted"); end
      idle_masters();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle_masters();
      hang = '0;
      test_reset();
      test_read();
      test_round_robin();
      test_unmapped();
      test_reset_mid();
      test_back_to_back();
`ifdef WB_INTERCON_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
